vh_sweep_capture: RTL and testbench

Exhaustive stimulus/response harness for combinational or pipelined expression-test modules. It sweeps every value of an `A_WIDTH`-bit input into a device under test, and captures each `Y_WIDTH`-bit response after a fixed DUT latency. Responses are compacted into a MISR signature, and a pass flag reports whether the signature matches an expected value. It sits on the far side of the `a`/`y` interface of each expression-test module and gives the FPGA/ASIC flow a self-checking wrapper.

---
 rtl/vh_sweep_capture_pkg.sv | 32 +++
 rtl/vh_sweep_capture_if.sv | 26 ++
 rtl/vh_sweep_capture_misr.sv | 41 ++++
 rtl/vh_sweep_capture.sv | 108 ++++++++++
 tb/tb_vh_sweep_capture.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vh_sweep_capture_pkg.sv
// Shared types and helpers for the exhaustive sweep/capture harness:
// FSM encoding, MISR seed, default polynomial and the response fold.
package vh_harness_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [63:0] SEED = '1;
    localparam logic [63:0] POLY_DEFAULT = 64'h0000_0000_04C1_1DB7;

    // XOR every sig_w-bit chunk of a zero-extended response together.
    function automatic logic [63:0] fold(
        input logic [255:0] din,
        input int           sig_w
    );
        logic [255:0] sh;
        logic [63:0]  mask;
        logic [63:0]  acc;
        mask = (sig_w >= 64) ? '1 : ((64'd1 << sig_w) - 64'd1);
        acc  = '0;
        for (int c = 0; c < 32; c++) begin
            sh  = din >> (c * sig_w);
            acc = acc ^ (sh[63:0] & mask);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vh_sweep_capture_if.sv
// Harness-side bundle: sweep control, DUT stimulus/response and result.
interface vh_sweep_capture_if #(
    parameter int A_WIDTH   = 4,
    parameter int Y_WIDTH   = 16,
    parameter int SIG_WIDTH = 32
);
    logic                 start;
    logic [SIG_WIDTH-1:0] expect_sig;
    logic [A_WIDTH-1:0]   dut_a;
    logic [Y_WIDTH-1:0]   dut_y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [SIG_WIDTH-1:0] signature;
    logic [A_WIDTH:0]     count;

    modport master (
        output start, expect_sig, dut_y,
        input  dut_a, busy, done, pass, signature, count
    );

    modport slave (
        input  start, expect_sig, dut_y,
        output dut_a, busy, done, pass, signature, count
    );
endinterface

// File: rtl/vh_sweep_capture_misr.sv
// Multiple-input signature register; the response is folded down to
// SIG_WIDTH bits before being XORed into the shifted signature.
module vh_misr
    import vh_harness_pkg::*;
#(
    parameter int          SIG_WIDTH = 32,
    parameter logic [63:0] POLY      = POLY_DEFAULT,
    parameter int          IN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [SIG_WIDTH-1:0] sig
);

    localparam logic [SIG_WIDTH-1:0] SEED_W = SIG_WIDTH'(SEED);
    localparam logic [SIG_WIDTH-1:0] POLY_W = SIG_WIDTH'(POLY);

    logic [SIG_WIDTH-1:0] folded;
    logic [SIG_WIDTH-1:0] nxt;

    always_comb begin
        folded = SIG_WIDTH'(fold(256'(din), SIG_WIDTH));
        nxt    = {sig[SIG_WIDTH-2:0], 1'b0}
               ^ (sig[SIG_WIDTH-1] ? POLY_W : '0)
               ^ folded;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED_W;
        end else if (init) begin
            sig <= SEED_W;
        end else if (en) begin
            sig <= nxt;
        end
    end

endmodule

// File: rtl/vh_sweep_capture.sv
// Sweeps every A_WIDTH-bit vector into a DUT, captures each response
// after LATENCY cycles into a MISR and flags a golden-signature match.
module vh_sweep_capture
    import vh_harness_pkg::*;
#(
    parameter int          A_WIDTH   = 4,
    parameter int          Y_WIDTH   = 16,
    parameter int          LATENCY   = 0,
    parameter int          SIG_WIDTH = 32,
    parameter logic [63:0] POLY      = POLY_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    vh_sweep_capture_if.slave bus
);

    localparam logic [A_WIDTH-1:0] A_LAST = '1;
    localparam logic [2:0]         D_LAST = 3'(LATENCY - 1);

    state_t             state;
    state_t             state_nxt;
    logic [A_WIDTH-1:0] a_q;
    logic [A_WIDTH:0]   count_q;
    logic [2:0]         dcnt;
    logic               pass_q;
    logic               accept;
    logic               drive;
    logic               capture;

    assign accept = (state == S_IDLE) && bus.start;
    assign drive  = (state == S_DRIVE);

    // Valid pipe mirrors the DUT depth so each capture lines up with its vector.
    generate
        if (LATENCY == 0) begin : g_lat0
            assign capture = drive;
        end else begin : g_latn
            logic [LATENCY-1:0] vpipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe <= '0;
                end else begin
                    vpipe <= LATENCY'({vpipe, drive});
                end
            end
            assign capture = vpipe[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_DRIVE;
            S_DRIVE: if (a_q == A_LAST) state_nxt = (LATENCY > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (dcnt == D_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            count_q <= '0;
            dcnt    <= '0;
            pass_q  <= 1'b0;
        end else begin
            dcnt <= (state == S_DRAIN) ? dcnt + 3'd1 : 3'd0;
            if (accept) begin
                a_q     <= '0;
                count_q <= '0;
                pass_q  <= 1'b0;
            end else begin
                if (drive && (a_q != A_LAST)) a_q <= a_q + 1'b1;
                if (capture) count_q <= count_q + 1'b1;
                if (state == S_DONE) pass_q <= (bus.signature == bus.expect_sig);
            end
        end
    end

    vh_misr #(
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY),
        .IN_WIDTH  (Y_WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (accept),
        .en    (capture),
        .din   (bus.dut_y),
        .sig   (bus.signature)
    );

    assign bus.dut_a = a_q;
    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_DONE);
    assign bus.pass  = pass_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_vh_sweep_capture.sv
// Scoreboard bench: randomized sweeps on three harness configurations
// checked against a plain-arithmetic MISR reference model.
`timescale 1ns/1ps
module tb_vh_sweep_capture;

    localparam int LAT = 3;
    localparam logic [63:0] P32 = 64'h04C1_1DB7;
    localparam logic [63:0] P8  = 64'h07;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vh_sweep_capture_if #(.A_WIDTH(4), .Y_WIDTH(16), .SIG_WIDTH(32)) m_if ();
    vh_sweep_capture_if #(.A_WIDTH(1), .Y_WIDTH(1),  .SIG_WIDTH(8))  s_if ();
    vh_sweep_capture_if #(.A_WIDTH(1), .Y_WIDTH(40), .SIG_WIDTH(32)) w_if ();

    vh_sweep_capture #(.A_WIDTH(4), .Y_WIDTH(16), .LATENCY(LAT), .SIG_WIDTH(32), .POLY(P32))
        u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
    vh_sweep_capture #(.A_WIDTH(1), .Y_WIDTH(1), .LATENCY(0), .SIG_WIDTH(8), .POLY(P8))
        u_small (.clk(clk), .rst_n(rst_n), .bus(s_if));
    vh_sweep_capture #(.A_WIDTH(1), .Y_WIDTH(40), .LATENCY(0), .SIG_WIDTH(32), .POLY(P32))
        u_wide (.clk(clk), .rst_n(rst_n), .bus(w_if));

    // Behavioural DUTs: a LAT-deep registered lookup table, a wire, a constant.
    logic [15:0] lut [16];
    logic [3:0]  p0, p1, p2;
    logic        s_sel = 1'b0;
    logic [39:0] w_y   = '0;

    always @(posedge clk) begin
        p0 <= m_if.dut_a;
        p1 <= p0;
        p2 <= p1;
    end

    assign m_if.dut_y = lut[p2];
    assign s_if.dut_y = s_sel ? s_if.dut_a : 1'b0;
    assign w_if.dut_y = w_y;

    typedef struct {
        logic [63:0] sig;
        logic        pass;
        int          cnt;
    } exp_t;

    exp_t mq[$];
    exp_t sq[$];
    exp_t wq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signature after shifting in each folded response in order, from an all-ones seed.
    function automatic logic [63:0] misr_model(input int sw, input logic [63:0] poly,
                                               input logic [63:0] ys[$]);
        logic [63:0] mask;
        logic [63:0] s;
        logic        msb;
        mask = (sw == 64) ? '1 : ((64'd1 << sw) - 64'd1);
        s = mask;
        foreach (ys[i]) begin
            msb = ((s >> (sw - 1)) & 64'd1) != 64'd0;
            s = ((s << 1) ^ (msb ? poly : 64'd0) ^ ys[i]) & mask;
        end
        return s;
    endfunction

    // Monitors: pop on every done, check pass one cycle later once registered.
    initial begin : mon
        exp_t e;
        int   mb = 0, sb = 0, wb = 0;
        logic mp = 0, sp = 0, wp = 0;
        logic mpe = 0, spe = 0, wpe = 0;
        forever begin
            @(negedge clk);
            if (mp) begin chk("main_pass", 64'(m_if.pass), 64'(mpe)); mp = 0; end
            if (sp) begin chk("small_pass", 64'(s_if.pass), 64'(spe)); sp = 0; end
            if (wp) begin chk("wide_pass", 64'(w_if.pass), 64'(wpe)); wp = 0; end
            mb = m_if.busy ? mb + 1 : 0;
            sb = s_if.busy ? sb + 1 : 0;
            wb = w_if.busy ? wb + 1 : 0;
            if (m_if.done) begin
                if (mq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL main_unexpected_done: got done=1 expected none");
                end else begin
                    e = mq.pop_front();
                    chk("main_sig", 64'(m_if.signature), e.sig);
                    chk("main_count", 64'(m_if.count), 64'(e.cnt));
                    chk("main_busy_cycles", 64'(mb), 64'(16 + LAT + 1));
                    mp = 1; mpe = e.pass;
                end
            end
            if (s_if.done) begin
                if (sq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL small_unexpected_done: got done=1 expected none");
                end else begin
                    e = sq.pop_front();
                    chk("small_sig", 64'(s_if.signature), e.sig);
                    chk("small_count", 64'(s_if.count), 64'(e.cnt));
                    chk("small_busy_cycles", 64'(sb), 64'd3);
                    sp = 1; spe = e.pass;
                end
            end
            if (w_if.done) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wide_unexpected_done: got done=1 expected none");
                end else begin
                    e = wq.pop_front();
                    chk("wide_sig", 64'(w_if.signature), e.sig);
                    chk("wide_count", 64'(w_if.count), 64'(e.cnt));
                    chk("wide_busy_cycles", 64'(wb), 64'd3);
                    wp = 1; wpe = e.pass;
                end
            end
        end
    end

    task automatic rand_lut();
        for (int k = 0; k < 16; k++) lut[k] = 16'($urandom);
    endtask

    function automatic logic [63:0] main_model();
        logic [63:0] ys[$];
        for (int k = 0; k < 16; k++) ys.push_back(64'(lut[k]));
        return misr_model(32, P32, ys);
    endfunction

    task automatic wait_done(input string name, output logic seen);
        int n = 0;
        while (!m_if.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = m_if.done;
        chk(name, 64'(m_if.done), 64'd1);
    endtask

    task automatic main_sweep(input bit mid_start, input bit good);
        exp_t e;
        logic [63:0] s;
        logic seen;
        s = main_model();
        m_if.expect_sig = good ? s[31:0] : (s[31:0] ^ (32'd1 << $urandom_range(0, 31)));
        e.sig = s; e.pass = good; e.cnt = 16;
        mq.push_back(e);
        @(negedge clk); m_if.start = 1'b1;
        @(negedge clk); m_if.start = 1'b0;
        if (mid_start) begin
            repeat (3) @(negedge clk);
            m_if.start = 1'b1;
            @(negedge clk); m_if.start = 1'b0;
        end
        wait_done("main_done_seen", seen);
        @(negedge clk);
    endtask

    task automatic small_sweep(input bit sel, input logic [7:0] expv);
        exp_t e;
        logic [63:0] ys[$];
        logic [63:0] s;
        s_sel = sel;
        s_if.expect_sig = expv;
        ys.push_back(64'd0);
        ys.push_back(sel ? 64'd1 : 64'd0);
        s = misr_model(8, P8, ys);
        e.sig = s; e.pass = (s[7:0] == expv); e.cnt = 2;
        sq.push_back(e);
        @(negedge clk); s_if.start = 1'b1;
        @(negedge clk); s_if.start = 1'b0;
        chk("small_busy_after_start", 64'(s_if.busy), 64'd1);
        chk("small_a0", 64'(s_if.dut_a), 64'd0);
        @(negedge clk);
        chk("small_sig_first", 64'(s_if.signature), 64'hF9);
        @(negedge clk);
        chk("small_done_timing", 64'(s_if.done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wide_sweep(input logic [39:0] y, input bit good);
        exp_t e;
        logic [63:0] ys[$];
        logic [63:0] f;
        logic [63:0] s;
        int n = 0;
        w_y = y;
        f = 64'(y[31:0]) ^ 64'(y[39:32]);
        ys.push_back(f);
        ys.push_back(f);
        s = misr_model(32, P32, ys);
        w_if.expect_sig = good ? s[31:0] : (s[31:0] ^ 32'h8000_0001);
        e.sig = s; e.pass = good; e.cnt = 2;
        wq.push_back(e);
        @(negedge clk); w_if.start = 1'b1;
        @(negedge clk); w_if.start = 1'b0;
        while (!w_if.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wide_done_seen", 64'(w_if.done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_main(input string tag);
        chk({tag, "_dut_a"}, 64'(m_if.dut_a), 64'd0);
        chk({tag, "_busy"}, 64'(m_if.busy), 64'd0);
        chk({tag, "_done"}, 64'(m_if.done), 64'd0);
        chk({tag, "_pass"}, 64'(m_if.pass), 64'd0);
        chk({tag, "_count"}, 64'(m_if.count), 64'd0);
        chk({tag, "_sig"}, 64'(m_if.signature), 64'hFFFF_FFFF);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        logic [63:0] s;
        logic seen;
        int n;
        m_if.start = 1'b0; m_if.expect_sig = '0;
        s_if.start = 1'b0; s_if.expect_sig = '0;
        w_if.start = 1'b0; w_if.expect_sig = '0;
        rand_lut();
        repeat (3) @(negedge clk);
        chk_reset_main("reset");
        chk("reset_small_sig", 64'(s_if.signature), 64'hFF);
        chk("reset_wide_sig", 64'(w_if.signature), 64'hFFFF_FFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        small_sweep(1'b0, 8'hF5);
        small_sweep(1'b1, 8'hF5);

        wide_sweep(40'hFF_0000_0000, 1'b1);
        wide_sweep({8'($urandom), 32'($urandom)}, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_lut();
            main_sweep(r[0], ($urandom_range(0, 1) == 1));
        end

        // Start held high: two identical sweeps with one idle cycle between.
        rand_lut();
        s = main_model();
        m_if.expect_sig = s[31:0];
        e.sig = s; e.pass = 1'b1; e.cnt = 16;
        mq.push_back(e);
        mq.push_back(e);
        @(negedge clk); m_if.start = 1'b1;
        @(negedge clk);
        wait_done("b2b_first_done", seen);
        @(negedge clk);
        chk("b2b_idle_gap", 64'(m_if.busy), 64'd0);
        @(negedge clk);
        chk("b2b_restart", 64'(m_if.busy), 64'd1);
        m_if.start = 1'b0;
        wait_done("b2b_second_done", seen);
        @(negedge clk);

        // Reset asserted mid-sweep at vector 5.
        rand_lut();
        @(negedge clk); m_if.start = 1'b1;
        @(negedge clk); m_if.start = 1'b0;
        n = 0;
        while (m_if.dut_a != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_vec5", 64'(m_if.dut_a), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_main("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        main_sweep(1'b0, 1'b1);

        repeat (5) @(negedge clk);
        chk("main_queue_drained", 64'(mq.size()), 64'd0);
        chk("small_queue_drained", 64'(sq.size()), 64'd0);
        chk("wide_queue_drained", 64'(wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
